// File: rtl/aes_subshift_stage_if.sv
// Handshake bundle for aes_subshift_stage: one 128-bit AES state in, one out.
// AES_SUBSHIFT_INV_EN adds the inv select that travels with the input state.
interface aes_subshift_stage_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         out_last;
`ifdef AES_SUBSHIFT_INV_EN
   logic         inv;
`endif

   modport master (
`ifdef AES_SUBSHIFT_INV_EN
      output inv,
`endif
      output in_valid,
      output in_state,
      output in_last,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_state,
      input  out_last
   );

   modport slave (
`ifdef AES_SUBSHIFT_INV_EN
      input  inv,
`endif
      input  in_valid,
      input  in_state,
      input  in_last,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_state,
      output out_last
   );
endinterface

// File: rtl/aes_subshift_stage.sv
// Iterative AES SubBytes + ShiftRows: LANES arithmetic S-boxes per cycle, registered result.
// Define AES_SUBSHIFT_INV_EN to add InvSubBytes/InvShiftRows selected by bus.inv.
module aes_subshift_stage #(
   parameter int unsigned LANES = 4  // 4, 8 or 16
) (
   input logic                 clk,
   input logic                 rst_n,
   aes_subshift_stage_if.slave bus
);

   localparam int unsigned NSTEP     = 16 / LANES;
   localparam logic [3:0]  LAST_STEP = 4'(NSTEP - 1);

   typedef enum logic [1:0] {StIdle, StSub, StOut} state_e;

   state_e       r_fsm;
   logic [3:0]   r_step;
   logic [127:0] r_work;
   logic         r_work_last;
   logic [127:0] r_out_state;
   logic         r_out_last;
   logic         r_out_valid;
`ifdef AES_SUBSHIFT_INV_EN
   logic         r_inv;
`endif

   logic         w_accept;
   logic [127:0] w_work_sub;
   logic [127:0] w_shifted;
   logic [7:0]   w_lane_in  [LANES];
   logic [7:0]   w_lane_out [LANES];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (i != 0) r = gf_mul(r, a);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = s;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
         end
      end
      return o;
   endfunction

`ifdef AES_SUBSHIFT_INV_EN
   function automatic logic [7:0] inv_affine(input logic [7:0] s);
      return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = s;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
         end
      end
      return o;
   endfunction
`endif

   // r_step stays within 0..NSTEP-1, so every lane addresses a real byte
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_lane_in[l] = r_work[127 - 8 * (32'(r_step) * LANES + l) -: 8];
`ifdef AES_SUBSHIFT_INV_EN
      assign w_lane_out[l] = r_inv ? gf_inv(inv_affine(w_lane_in[l]))
                                   : affine(gf_inv(w_lane_in[l]));
`else
      assign w_lane_out[l] = affine(gf_inv(w_lane_in[l]));
`endif
   end

   always_comb begin
      w_work_sub = r_work;
      for (int unsigned l = 0; l < LANES; l++) begin
         w_work_sub[127 - 8 * (32'(r_step) * LANES + l) -: 8] = w_lane_out[l];
      end
   end

`ifdef AES_SUBSHIFT_INV_EN
   assign w_shifted = r_inv ? inv_shift_rows(w_work_sub) : shift_rows(w_work_sub);
`else
   assign w_shifted = shift_rows(w_work_sub);
`endif

   assign bus.in_ready  = (r_fsm == StIdle) || ((r_fsm == StOut) && bus.out_ready);
   assign w_accept      = bus.in_valid && bus.in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_state = r_out_state;
   assign bus.out_last  = r_out_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm       <= StIdle;
         r_step      <= '0;
         r_work      <= '0;
         r_work_last <= 1'b0;
         r_out_state <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
`ifdef AES_SUBSHIFT_INV_EN
         r_inv       <= 1'b0;
`endif
      end else begin
         // w_accept is only possible in StIdle/StOut, never alongside the StSub update
         if (w_accept) begin
            r_work      <= bus.in_state;
            r_work_last <= bus.in_last;
            r_step      <= '0;
`ifdef AES_SUBSHIFT_INV_EN
            r_inv       <= bus.inv;
`endif
         end
         unique case (r_fsm)
            StIdle: begin
               if (w_accept) r_fsm <= StSub;
            end
            StSub: begin
               r_work <= w_work_sub;
               if (r_step == LAST_STEP) begin
                  r_step      <= '0;
                  r_out_state <= w_shifted;
                  r_out_last  <= r_work_last;
                  r_out_valid <= 1'b1;
                  r_fsm       <= StOut;
               end else begin
                  r_step <= r_step + 4'd1;
               end
            end
            StOut: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_fsm       <= w_accept ? StSub : StIdle;
               end
            end
            default: r_fsm <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_subshift_stage.sv
// Scoreboard bench for aes_subshift_stage: table-based AES model, queued expectations.
// Build with +define+AES_SUBSHIFT_INV_EN to also exercise the inverse path.
module tb_aes_subshift_stage;
   parameter int unsigned LANES = 4;
   localparam int unsigned NSTEP = 16 / LANES;

   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   aes_subshift_stage_if bus();

   aes_subshift_stage #(.LANES(LANES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rdy_mode = 1;  // 0: out_ready low, 1: high, 2: random

   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]   sbox  [256];
   logic [7:0]   isbox [256];
   logic [127:0] exp_q      [$];
   logic         exp_last_q [$];
   int           acc_q      [$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box from exp/log tables of generator 3, then the bitwise affine rule
   task automatic build_tables();
      logic [7:0] e [256];
      int         lg [256];
      logic [7:0] x;
      logic [7:0] v;
      logic [7:0] s;
      x = 8'h01;
      for (int i = 0; i < 255; i++) begin
         e[i]  = x;
         lg[x] = i;
         x     = x ^ xt(x);
      end
      for (int b = 0; b < 256; b++) begin
         v = (b == 0) ? 8'h00 : e[(255 - lg[b]) % 255];
         for (int i = 0; i < 8; i++) begin
            s[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8]
                   ^ ((8'h63 >> i) & 8'h01) != 0;
         end
         sbox[b] = s;
      end
      for (int b = 0; b < 256; b++) isbox[sbox[b]] = 8'(b);
   endtask

   function automatic logic [127:0] model(input logic [127:0] st, input logic inv);
      logic [7:0]   b [16];
      logic [127:0] o;
      int           src;
      for (int k = 0; k < 16; k++) begin
         b[k] = st[127 - 8 * k -: 8];
         b[k] = inv ? isbox[b[k]] : sbox[b[k]];
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
            o[127 - 8 * (r + 4 * c) -: 8] = b[r + 4 * src];
         end
      end
      return o;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge
   task automatic send_exp(input logic [127:0] st, input logic last, input logic inv,
                           input logic [127:0] expv);
      bit done = 0;
      bus.in_valid = 1'b1;
      bus.in_state = st;
      bus.in_last  = last;
`ifdef AES_SUBSHIFT_INV_EN
      bus.inv      = inv;
`endif
      for (int t = 0; t < 500 && !done; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            done = 1;
            exp_q.push_back(expv);
            exp_last_q.push_back(last);
            acc_q.push_back(cyc + 1);
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got no in_ready, want accept (inv=%0b)", inv);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
      bus.in_last  = 1'($urandom);
`ifdef AES_SUBSHIFT_INV_EN
      bus.inv      = 1'($urandom);
`endif
   endtask

   task automatic send(input logic [127:0] st, input logic last, input logic inv);
      send_exp(st, last, inv, model(st, inv));
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: latency on each out_valid rise, data on each handshake
   initial begin
      logic prev_v;
      logic [127:0] e;
      logic el;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_v = 1'b0;
         end else begin
            if (bus.out_valid && !prev_v) begin
               if (acc_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL spurious_valid: got out_valid=1, want 0");
               end else begin
                  check("latency", 128'(cyc - acc_q.pop_front()), 128'(NSTEP));
               end
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL extra_output: got %h, want none", bus.out_state);
               end else begin
                  e  = exp_q.pop_front();
                  el = exp_last_q.pop_front();
                  check("out_state", bus.out_state, e);
                  check("out_last", 128'(bus.out_last), 128'(el));
               end
            end
            prev_v = bus.out_valid;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] a;
      logic [127:0] b;
      logic [7:0]   last_pat;
      build_tables();
      bus.in_valid = 1'b0;
      bus.in_state = '0;
      bus.in_last  = 1'b0;
`ifdef AES_SUBSHIFT_INV_EN
      bus.inv      = 1'b0;
`endif
      #2;
      check("rst_out_valid", 128'(bus.out_valid), 128'(0));
      check("rst_out_state", bus.out_state, 128'(0));
      check("rst_out_last", 128'(bus.out_last), 128'(0));
      check("rst_in_ready", 128'(bus.in_ready), 128'(1));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Known answers and ShiftRows routing, back-to-back with out_ready high
      send_exp(FIPS_IN, 1'b0, 1'b0, FIPS_OUT);
      send_exp({16{8'h00}}, 1'b1, 1'b0, {16{8'h63}});
      send_exp({16{8'h53}}, 1'b0, 1'b0, {16{8'hed}});
      send(128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b0);
      drain();

      // Backpressure: out_ready low, second state waiting on in_valid
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      send(a, 1'b1, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_state = b;
      bus.in_last  = 1'b0;
      repeat (NSTEP) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_in_ready", 128'(bus.in_ready), 128'(0));
         check("bp_out_valid", 128'(bus.out_valid), 128'(1));
         check("bp_out_state", bus.out_state, model(a, 1'b0));
         check("bp_out_last", 128'(bus.out_last), 128'(1));
      end
      rdy_mode = 1;
      send(b, 1'b0, 1'b0);
      drain();

      // Random back-to-back with random out_ready
      rdy_mode = 2;
      last_pat = 8'b10110010;
      for (int i = 0; i < 8; i++) begin
`ifdef AES_SUBSHIFT_INV_EN
         send({$urandom, $urandom, $urandom, $urandom}, last_pat[7 - i], 1'($urandom));
`else
         send({$urandom, $urandom, $urandom, $urandom}, last_pat[7 - i], 1'b0);
`endif
      end
      rdy_mode = 1;
      drain();

      // Reset while the accepted state is still being substituted
      send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
      rst_n = 1'b0;
      exp_q.delete();
      exp_last_q.delete();
      acc_q.delete();
      #1;
      check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
      check("midrst_out_state", bus.out_state, 128'(0));
      check("midrst_out_last", 128'(bus.out_last), 128'(0));
      check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NSTEP + 4; i++) begin
         @(negedge clk);
         check("postrst_out_valid", 128'(bus.out_valid), 128'(0));
      end
      check("postrst_in_ready", 128'(bus.in_ready), 128'(1));
      @(posedge clk);
      #1;
      send_exp(FIPS_IN, 1'b1, 1'b0, FIPS_OUT);
      drain();

`ifdef AES_SUBSHIFT_INV_EN
      send_exp(FIPS_OUT, 1'b0, 1'b1, FIPS_IN);
      send(128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b1);
      drain();
`endif

      check("queue_empty", 128'(exp_q.size() + acc_q.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
